// File: rtl/mmu_pkg.sv
// Shared types for the TLB-based MMU: fault cause codes, per-entry
// flag bits and the permission-check helper used by the top level.
package mmu_pkg;

   localparam int MMU_CAUSE_W = 2;

   typedef enum logic [MMU_CAUSE_W-1:0] {
      MMU_CAUSE_NONE  = 2'd0,
      MMU_CAUSE_MISS  = 2'd1,
      MMU_CAUSE_WPROT = 2'd2
   } mmu_cause_e;

   // Width-independent part of a TLB entry. The vpn/ppn fields depend on
   // module parameters, so they are carried next to these flags in the CAM.
   typedef struct packed {
      logic valid;
      logic writable;
   } mmu_tlb_flags_t;

   // Outcome of a translated lookup: miss beats permission, stores to
   // read-only pages fault, everything else translates cleanly.
   function automatic mmu_cause_e mmu_check(input logic hit,
                                            input logic write,
                                            input logic writable);
      mmu_cause_e c;
      c = MMU_CAUSE_NONE;
      if (!hit)
         c = MMU_CAUSE_MISS;
      else if (write && !writable)
         c = MMU_CAUSE_WPROT;
      return c;
   endfunction

endpackage

// File: rtl/mmu_tlb_cam.sv
// Fully-associative TLB storage: combinational lookup plus fill, flush
// and round-robin replacement. Fills overwrite a matching valid entry in
// place so a vpn can never be resident twice.
module mmu_tlb_cam
   import mmu_pkg::*;
#(
   parameter int VPN_W   = 20,
   parameter int PPN_W   = 20,
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [VPN_W-1:0] i_lk_vpn,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_hit_idx,
   output logic [PPN_W-1:0] o_ppn,
   output logic             o_writable,
   input  logic             i_fill_valid,
   input  logic [VPN_W-1:0] i_fill_vpn,
   input  logic [PPN_W-1:0] i_fill_ppn,
   input  logic             i_fill_writable,
   input  logic             i_flush
);

   mmu_tlb_flags_t r_flags [ENTRIES];
   logic [VPN_W-1:0] r_vpn [ENTRIES];
   logic [PPN_W-1:0] r_ppn [ENTRIES];
   logic [IDX_W-1:0] r_ptr;

   logic             w_fill_hit;
   logic [IDX_W-1:0] w_fill_hit_idx;
   logic             w_inv_any;
   logic [IDX_W-1:0] w_inv_idx;
   logic             w_use_ptr;
   logic [IDX_W-1:0] w_tgt;
   logic             w_do_fill;

   // Lookup: at most one entry can match, so a plain OR-style scan is safe.
   always_comb begin
      o_hit      = 1'b0;
      o_hit_idx  = '0;
      o_ppn      = '0;
      o_writable = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (r_flags[i].valid && (r_vpn[i] == i_lk_vpn)) begin
            o_hit      = 1'b1;
            o_hit_idx  = IDX_W'(i);
            o_ppn      = r_ppn[i];
            o_writable = r_flags[i].writable;
         end
      end
   end

   // Fill target: in-place match, else lowest invalid slot, else pointer.
   always_comb begin
      w_fill_hit     = 1'b0;
      w_fill_hit_idx = '0;
      w_inv_any      = 1'b0;
      w_inv_idx      = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (r_flags[i].valid && (r_vpn[i] == i_fill_vpn)) begin
            w_fill_hit     = 1'b1;
            w_fill_hit_idx = IDX_W'(i);
         end
      end
      // Scan downward so the last assignment is the lowest free index.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!r_flags[i].valid) begin
            w_inv_any = 1'b1;
            w_inv_idx = IDX_W'(i);
         end
      end
      w_use_ptr = !w_fill_hit && !w_inv_any;
      w_tgt     = w_fill_hit ? w_fill_hit_idx : (w_inv_any ? w_inv_idx : r_ptr);
      w_do_fill = i_fill_valid && !i_flush && !rst;
   end

   // Valid/permission bits and replacement pointer; flush beats fill.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         for (int i = 0; i < ENTRIES; i++)
            r_flags[i] <= '0;
         r_ptr <= '0;
      end else if (w_do_fill) begin
         r_flags[w_tgt].valid    <= 1'b1;
         r_flags[w_tgt].writable <= i_fill_writable;
         if (w_use_ptr)
            r_ptr <= r_ptr + 1'b1;
      end
   end

   // Page-number payload needs no reset; it is qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (w_do_fill) begin
         r_vpn[w_tgt] <= i_fill_vpn;
         r_ppn[w_tgt] <= i_fill_ppn;
      end
   end

endmodule

// File: rtl/mmu_tlb.sv
// MMU top: TLB lookup, identity bypass for boot code, store-permission
// check and a single-entry registered response with valid/ready handshake.
module mmu_tlb
   import mmu_pkg::*;
#(
   parameter int VA_W      = 32,
   parameter int PA_W      = 32,
   parameter int PAGE_BITS = 12,
   parameter int ENTRIES   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [VA_W-1:0]           req_va,
   input  logic                      req_write,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [PA_W-1:0]           rsp_pa,
   output logic                      rsp_fault,
   output logic [MMU_CAUSE_W-1:0]    rsp_cause,
   input  logic                      fill_valid,
   input  logic [VA_W-PAGE_BITS-1:0] fill_vpn,
   input  logic [PA_W-PAGE_BITS-1:0] fill_ppn,
   input  logic                      fill_writable,
   input  logic                      flush
);

   localparam int VPN_W = VA_W - PAGE_BITS;
   localparam int PPN_W = PA_W - PAGE_BITS;
   localparam int IDX_W = $clog2(ENTRIES);

   logic             w_hit;
   logic [IDX_W-1:0] w_hit_idx;   // exposed by the CAM for debug probing
   logic [PPN_W-1:0] w_ppn;
   logic             w_writable;
   logic             w_accept;
   mmu_cause_e       w_cause;
   logic             w_fault;
   logic [PA_W-1:0]  w_pa;

   logic             r_valid;
   logic [PA_W-1:0]  r_pa;
   logic             r_fault;
   mmu_cause_e       r_cause;

   mmu_tlb_cam #(
      .VPN_W   (VPN_W),
      .PPN_W   (PPN_W),
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_cam (
      .clk             (clk),
      .rst             (rst),
      .i_lk_vpn        (req_va[VA_W-1:PAGE_BITS]),
      .o_hit           (w_hit),
      .o_hit_idx       (w_hit_idx),
      .o_ppn           (w_ppn),
      .o_writable      (w_writable),
      .i_fill_valid    (fill_valid),
      .i_fill_vpn      (fill_vpn),
      .i_fill_ppn      (fill_ppn),
      .i_fill_writable (fill_writable),
      .i_flush         (flush)
   );

   // Handshake plus translation result; bypass never faults.
   always_comb begin
      req_ready = !r_valid || rsp_ready;
      w_accept  = req_valid && req_ready;
      w_cause   = enable ? mmu_check(w_hit, req_write, w_writable) : MMU_CAUSE_NONE;
      w_fault   = (w_cause != MMU_CAUSE_NONE);
      if (!enable)
         w_pa = PA_W'(req_va);
      else if (w_fault)
         w_pa = '0;
      else
         w_pa = {w_ppn, req_va[PAGE_BITS-1:0]};
   end

   // Response register: loads on accept, drains on consume, holds under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pa    <= '0;
         r_fault <= 1'b0;
         r_cause <= MMU_CAUSE_NONE;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_pa    <= w_pa;
         r_fault <= w_fault;
         r_cause <= w_cause;
      end else if (rsp_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_valid;
   assign rsp_pa    = r_pa;
   assign rsp_fault = r_fault;
   assign rsp_cause = r_cause;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: bypass, miss/fill/hit, replacement order,
// simultaneous fill/flush/lookup, backpressure and mid-flight reset.
module tb_mmu_tlb;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_va;
   logic        req_write;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_pa;
   logic        rsp_fault;
   logic [1:0]  rsp_cause;
   logic        fill_valid;
   logic [19:0] fill_vpn;
   logic [19:0] fill_ppn;
   logic        fill_writable;
   logic        flush;

   int checks = 0;
   int errors = 0;

   mmu_tlb #(.VA_W(32), .PA_W(32), .PAGE_BITS(12), .ENTRIES(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_va        (req_va),
      .req_write     (req_write),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_pa        (rsp_pa),
      .rsp_fault     (rsp_fault),
      .rsp_cause     (rsp_cause),
      .fill_valid    (fill_valid),
      .fill_vpn      (fill_vpn),
      .fill_ppn      (fill_ppn),
      .fill_writable (fill_writable),
      .flush         (flush)
   );

   always #5 clk = ~clk;

   // One request with rsp_ready high; returns the registered response.
   task automatic do_req(input logic [31:0] va, input logic wr,
                         output logic v, output logic [31:0] pa,
                         output logic f, output logic [1:0] c);
      req_valid = 1'b1; req_va = va; req_write = wr;
      @(posedge clk); #1;
      req_valid = 1'b0;
      v = rsp_valid; pa = rsp_pa; f = rsp_fault; c = rsp_cause;
   endtask

   task automatic do_fill(input logic [19:0] vpn, input logic [19:0] ppn, input logic wr);
      fill_valid = 1'b1; fill_vpn = vpn; fill_ppn = ppn; fill_writable = wr;
      @(posedge clk); #1;
      fill_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_pa !== 32'h0) begin errors++; $display("FAIL reset_pa got %h exp 0", rsp_pa); end
      checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", rsp_fault); end
      checks++; if (rsp_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d exp 0", rsp_cause); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_bypass();
      logic v, f; logic [31:0] pa; logic [1:0] c;
      enable = 1'b0;
      do_req(32'h1234_5678, 1'b1, v, pa, f, c);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b exp 1", v); end
      checks++; if (pa !== 32'h1234_5678) begin errors++; $display("FAIL bypass_pa got %h exp 12345678", pa); end
      checks++; if (f !== 1'b0 || c !== 2'd0) begin errors++; $display("FAIL bypass_fault got %b/%0d exp 0/0", f, c); end
   endtask

   task automatic test_miss_fill_hit();
      logic v, f; logic [31:0] pa; logic [1:0] c;
      enable = 1'b1;
      do_req(32'h0000_5ABC, 1'b0, v, pa, f, c);
      checks++; if (f !== 1'b1 || c !== 2'd1 || pa !== 32'h0) begin errors++; $display("FAIL miss_first got f=%b c=%0d pa=%h exp 1/1/0", f, c, pa); end
      do_fill(20'h5, 20'h80, 1'b0);
      do_req(32'h0000_5ABC, 1'b0, v, pa, f, c);
      checks++; if (pa !== 32'h0008_0ABC) begin errors++; $display("FAIL hit_pa got %h exp 00080abc", pa); end
      checks++; if (f !== 1'b0 || c !== 2'd0) begin errors++; $display("FAIL hit_fault got %b/%0d exp 0/0", f, c); end
      do_req(32'h0000_5ABC, 1'b1, v, pa, f, c);
      checks++; if (f !== 1'b1 || c !== 2'd2 || pa !== 32'h0) begin errors++; $display("FAIL wprot got f=%b c=%0d pa=%h exp 1/2/0", f, c, pa); end
   endtask

   task automatic test_replacement();
      logic v, f; logic [31:0] pa; logic [1:0] c;
      logic [19:0] vpn;
      do_flush();
      for (int i = 0; i < 9; i++) begin
         vpn = 20'(i);
         do_fill(vpn, 20'h100 + vpn, 1'b1);
      end
      do_req(32'h0000_0234, 1'b0, v, pa, f, c);
      checks++; if (c !== 2'd1) begin errors++; $display("FAIL evict_vpn0 got cause %0d exp 1", c); end
      for (int i = 1; i < 9; i++) begin
         vpn = 20'(i);
         do_req({vpn, 12'h234}, 1'b1, v, pa, f, c);
         checks++; if (pa !== {20'h100 + vpn, 12'h234} || f !== 1'b0) begin errors++; $display("FAIL keep_vpn%0d got pa=%h f=%b exp %h/0", i, pa, f, {20'h100 + vpn, 12'h234}); end
      end
      do_fill(20'h9, 20'h109, 1'b1);
      do_req(32'h0000_1234, 1'b0, v, pa, f, c);
      checks++; if (c !== 2'd1) begin errors++; $display("FAIL evict_vpn1 got cause %0d exp 1", c); end
      do_req(32'h0000_9234, 1'b0, v, pa, f, c);
      checks++; if (pa !== 32'h0010_9234) begin errors++; $display("FAIL hit_vpn9 got %h exp 00109234", pa); end
      // In-place refill of vpn 3 must not move the pointer (still at 2).
      do_fill(20'h3, 20'h33, 1'b1);
      do_req(32'h0000_3234, 1'b0, v, pa, f, c);
      checks++; if (pa !== 32'h0003_3234) begin errors++; $display("FAIL refill_vpn3 got %h exp 00033234", pa); end
      do_fill(20'hA, 20'h10A, 1'b1);
      do_req(32'h0000_2234, 1'b0, v, pa, f, c);
      checks++; if (c !== 2'd1) begin errors++; $display("FAIL evict_vpn2 got cause %0d exp 1", c); end
      do_req(32'h0000_4234, 1'b0, v, pa, f, c);
      checks++; if (pa !== 32'h0010_4234) begin errors++; $display("FAIL keep_vpn4 got %h exp 00104234", pa); end
      do_req(32'h0000_3234, 1'b0, v, pa, f, c);
      checks++; if (pa !== 32'h0003_3234) begin errors++; $display("FAIL keep_vpn3 got %h exp 00033234", pa); end
   endtask

   task automatic test_simultaneous();
      logic v, f; logic [31:0] pa; logic [1:0] c;
      logic [31:0] tab [3];
      tab[0] = 32'h0002_0000; tab[1] = 32'h0000_3234; tab[2] = 32'h0000_A234;
      flush = 1'b1; fill_valid = 1'b1; fill_vpn = 20'h20; fill_ppn = 20'h220; fill_writable = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; fill_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         do_req(tab[i], 1'b0, v, pa, f, c);
         checks++; if (c !== 2'd1 || f !== 1'b1) begin errors++; $display("FAIL flush_fill_%0d got cause %0d exp 1", i, c); end
      end
      // Lookup in the fill cycle sees the old contents.
      fill_valid = 1'b1; fill_vpn = 20'h5; fill_ppn = 20'h55; fill_writable = 1'b1;
      do_req(32'h0000_5123, 1'b0, v, pa, f, c);
      fill_valid = 1'b0;
      checks++; if (c !== 2'd1) begin errors++; $display("FAIL same_cycle_fill got cause %0d exp 1", c); end
      do_req(32'h0000_5123, 1'b0, v, pa, f, c);
      checks++; if (pa !== 32'h0005_5123 || f !== 1'b0) begin errors++; $display("FAIL after_fill got %h/%b exp 00055123/0", pa, f); end
      // A flush must not disturb an already-registered response.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_va = 32'h0000_5123; req_write = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      do_flush();
      checks++; if (rsp_valid !== 1'b1 || rsp_pa !== 32'h0005_5123 || rsp_fault !== 1'b0) begin errors++; $display("FAIL flush_hold got v=%b pa=%h exp 1/00055123", rsp_valid, rsp_pa); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      do_req(32'h0000_5123, 1'b0, v, pa, f, c);
      checks++; if (c !== 2'd1) begin errors++; $display("FAIL flush_effect got cause %0d exp 1", c); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va_tab [4];
      logic [31:0] exp_tab [4];
      logic [31:0] held;
      logic held_ok, acc, cons;
      int sent, recv;
      for (int i = 0; i < 4; i++) begin
         do_fill(20'h11 + 20'(i), 20'h211 + 20'(i), 1'b1);
         va_tab[i]  = {20'h11 + 20'(i), 12'h00 + 12'(i)};
         exp_tab[i] = {20'h211 + 20'(i), 12'h00 + 12'(i)};
      end
      sent = 0; recv = 0; held_ok = 1'b0; held = '0;
      for (int cyc = 0; cyc < 16 && recv < 4; cyc++) begin
         req_valid = (sent < 4);
         req_va    = (sent < 4) ? va_tab[sent] : 32'h0;
         req_write = 1'b0;
         rsp_ready = !(cyc >= 1 && cyc <= 3);
         #4;
         if (rsp_valid && !rsp_ready) begin
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", req_ready); end
            if (held_ok) begin
               checks++; if (rsp_pa !== held) begin errors++; $display("FAIL stall_hold got %h exp %h", rsp_pa, held); end
            end
            held = rsp_pa; held_ok = 1'b1;
         end
         acc  = req_valid && req_ready;
         cons = rsp_valid && rsp_ready;
         if (cons) begin
            checks++; if (rsp_pa !== exp_tab[recv]) begin errors++; $display("FAIL stream_%0d got %h exp %h", recv, rsp_pa, exp_tab[recv]); end
            recv++;
         end
         @(posedge clk); #1;
         if (acc) sent++;
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      checks++; if (recv !== 4 || sent !== 4) begin errors++; $display("FAIL stream_count got sent=%0d recv=%0d exp 4/4", sent, recv); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic v, f; logic [31:0] pa; logic [1:0] c;
      logic [31:0] tab [3];
      tab[0] = 32'h0001_1000; tab[1] = 32'h0003_0000; tab[2] = 32'h0003_3000;
      for (int i = 0; i < 4; i++)
         do_fill(20'h30 + 20'(i), 20'h330 + 20'(i), 1'b1);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_va = 32'h0003_0000; req_write = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_pa !== 32'h0033_0000) begin errors++; $display("FAIL pre_reset got v=%b pa=%h exp 1/00330000", rsp_valid, rsp_pa); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; rsp_ready = 1'b1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", rsp_valid); end
      for (int i = 0; i < 3; i++) begin
         do_req(tab[i], 1'b0, v, pa, f, c);
         checks++; if (c !== 2'd1 || pa !== 32'h0) begin errors++; $display("FAIL post_reset_%0d got c=%0d pa=%h exp 1/0", i, c, pa); end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; req_valid = 1'b0; req_va = '0; req_write = 1'b0;
      rsp_ready = 1'b1; fill_valid = 1'b0; fill_vpn = '0; fill_ppn = '0;
      fill_writable = 1'b0; flush = 1'b0;
      test_reset();
      test_bypass();
      test_miss_fill_hit();
      test_replacement();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
